// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM DDR deserializer.
//   pdm_state_e   : clock generator FSM states (IDLE, RUN, DRAIN)
//   DEF_*         : default parameter values for the block
//   HALF, NCH     : half PDM period and channel count at the default sizing
//   cnt_w()       : width of the divider counter for a given CLK_DIV
//   bit_cnt_w()   : width of the per-word bit counter for a given WORD_W
package pdm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } pdm_state_e;

  localparam int unsigned DEF_NUM_LINES  = 4;
  localparam int unsigned DEF_CLK_DIV    = 8;
  localparam int unsigned DEF_SAMPLE_DLY = 2;
  localparam int unsigned DEF_WORD_W     = 16;

  localparam int unsigned HALF = DEF_CLK_DIV / 2;
  localparam int unsigned NCH  = 2 * DEF_NUM_LINES;

  // Counter holding 0..clk_div-1.
  function automatic int unsigned cnt_w(input int unsigned clk_div);
    return (clk_div > 1) ? $clog2(clk_div) : 1;
  endfunction

  // Counter holding 0..word_w-1.
  function automatic int unsigned bit_cnt_w(input int unsigned word_w);
    return (word_w > 1) ? $clog2(word_w) : 1;
  endfunction

endpackage

// File: rtl/pdm_ddr_deserializer_clk_gen.sv
// PDM bit clock generator and sample strobe source.
// Ports:
//   clk, rst   : system clock, synchronous active-high reset
//   en         : run request
//   pdm_clk    : registered PDM bit clock, 50% duty, CLK_DIV clk cycles per period
//   rise_stb   : one-cycle strobe SAMPLE_DLY cycles after the pdm_clk rising edge
//   fall_stb   : one-cycle strobe SAMPLE_DLY cycles after the pdm_clk falling edge
//   state_o    : current FSM state (debug / observation)
// Dropping en never truncates a PDM period: the FSM finishes the period it is in
// (DRAIN) before parking in IDLE, so the microphones never see a runt pulse.
module pdm_clk_gen
  import pdm_pkg::*;
#(
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
  parameter int unsigned SAMPLE_DLY = DEF_SAMPLE_DLY
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  output logic       pdm_clk,
  output logic       rise_stb,
  output logic       fall_stb,
  output pdm_state_e state_o
);

  localparam int unsigned CW = cnt_w(CLK_DIV);
  localparam int unsigned HALF_DIV = CLK_DIV / 2;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_DIV);
  localparam logic [CW-1:0] CNT_RISE = CW'(SAMPLE_DLY);
  localparam logic [CW-1:0] CNT_FALL = CW'(HALF_DIV + SAMPLE_DLY);

  pdm_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          pdm_clk_q, pdm_clk_d;

  always_comb begin
    cnt_inc = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (en) state_d = RUN;
      end
      RUN: begin
        cnt_d = cnt_inc;
        if (!en) state_d = DRAIN;
      end
      DRAIN: begin
        // Re-enable wins over the end-of-period exit so cnt never restarts.
        if (en) begin
          state_d = RUN;
          cnt_d   = cnt_inc;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Computed from the next state/count so the registered clock always
    // matches (state != IDLE && cnt < HALF) in the cycle it is visible.
    pdm_clk_d = (state_d != IDLE) && (cnt_d < CNT_HALF);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pdm_clk_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pdm_clk_q <= pdm_clk_d;
    end
  end

  assign pdm_clk  = pdm_clk_q;
  assign rise_stb = (state_q != IDLE) && (cnt_q == CNT_RISE);
  assign fall_stb = (state_q != IDLE) && (cnt_q == CNT_FALL);
  assign state_o  = state_q;

endmodule

// File: rtl/pdm_ddr_deserializer.sv
// Multi-line PDM microphone front end.
// Generates the PDM bit clock, samples NUM_LINES DDR data lines (two mics per
// line: one in the pdm_clk high half, one in the low half) and packs each of
// the NCH = 2*NUM_LINES channels into WORD_W-bit words, MSB = oldest bit.
// Ports:
//   clk, rst    : system clock, synchronous active-high reset
//   en          : run request for the PDM clock and capture
//   pdm_clk     : PDM bit clock to the microphones
//   pdm_data    : asynchronous DDR data lines
//   out_valid   : a bundle of NCH words is available
//   out_ready   : downstream accepts the bundle
//   out_data    : channel c at [c*WORD_W +: WORD_W]; channel 2k = line k high half,
//                 channel 2k+1 = line k low half
//   overflow    : sticky, a completed bundle was dropped
//   ovf_clr     : clears overflow (a same-cycle drop wins)
// Handshake: a bundle transfers on a cycle where out_valid & out_ready are both 1.
// While out_valid=1 and out_ready=0 out_data holds. A new bundle replaces the
// held one only if it is accepted in that same cycle; otherwise it is dropped.
module pdm_ddr_deserializer
  import pdm_pkg::*;
#(
  parameter int unsigned NUM_LINES  = DEF_NUM_LINES,
  parameter int unsigned CLK_DIV    = DEF_CLK_DIV,
  parameter int unsigned SAMPLE_DLY = DEF_SAMPLE_DLY,
  parameter int unsigned WORD_W     = DEF_WORD_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  output logic                            pdm_clk,
  input  logic [NUM_LINES-1:0]            pdm_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [2*NUM_LINES*WORD_W-1:0]   out_data,
  output logic                            overflow,
  input  logic                            ovf_clr
);

  localparam int unsigned NCH_L = 2 * NUM_LINES;
  localparam int unsigned BW    = bit_cnt_w(WORD_W);
  localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);

  logic       rise_stb, fall_stb;
  pdm_state_e clk_state;

  pdm_clk_gen #(
    .CLK_DIV   (CLK_DIV),
    .SAMPLE_DLY(SAMPLE_DLY)
  ) u_clk_gen (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .pdm_clk (pdm_clk),
    .rise_stb(rise_stb),
    .fall_stb(fall_stb),
    .state_o (clk_state)
  );

  // Two-flop synchroniser per line.
  logic [NUM_LINES-1:0] sync1_q, sync1_d;
  logic [NUM_LINES-1:0] sync2_q, sync2_d;

  logic [NCH_L-1:0][WORD_W-1:0] sh_q, sh_d;
  logic [BW-1:0]                bit_cnt_q, bit_cnt_d;
  logic                         out_valid_q, out_valid_d;
  logic [NCH_L*WORD_W-1:0]      out_data_q, out_data_d;
  logic                         overflow_q, overflow_d;
  logic                         word_done;
  logic                         ovf_set;

  always_comb begin
    sync1_d = pdm_data;
    sync2_d = sync1_q;
  end

  // Capture path: shift registers and bit counter.
  always_comb begin
    sh_d      = sh_q;
    bit_cnt_d = bit_cnt_q;
    word_done = 1'b0;
    if (clk_state == IDLE) begin
      // Parking in IDLE discards any partial word.
      sh_d      = '0;
      bit_cnt_d = '0;
    end else begin
      for (int k = 0; k < NUM_LINES; k++) begin
        if (rise_stb) sh_d[2*k]   = {sh_q[2*k][WORD_W-2:0], sync2_q[k]};
        if (fall_stb) sh_d[2*k+1] = {sh_q[2*k+1][WORD_W-2:0], sync2_q[k]};
      end
      // The low-half bit closes each PDM period, so the word completes there.
      if (fall_stb) begin
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
          word_done = 1'b1;
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
    end
  end

  // Output holding register and overflow.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ovf_set     = word_done && out_valid_q && !out_ready;
    if (word_done) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        out_data_d  = sh_d;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
    overflow_d = ovf_set || (overflow_q && !ovf_clr);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      sh_q        <= '0;
      bit_cnt_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      sh_q        <= sh_d;
      bit_cnt_q   <= bit_cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_pdm_ddr_deserializer.sv
module tb_pdm_ddr_deserializer;
  localparam int NL   = 2;
  localparam int DIV  = 8;
  localparam int SD   = 2;
  localparam int W    = 8;
  localparam int NCH  = 2 * NL;
  localparam int HALF = DIV / 2;
  localparam int BW   = NCH * W;
  localparam int LAT  = 1 + (W - 1) * DIV + HALF + SD + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          pdm_clk;
  logic [NL-1:0] pdm_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [BW-1:0] out_data;
  logic          overflow;
  logic          ovf_clr = 1'b0;

  int checks = 0;
  int errors = 0;

  // Expected bundles, oldest first.
  logic [BW-1:0] exp_q[$];
  int bundles_made = 0;
  int bundles_dropped = 0;
  int mode = 0;          // 0 random, 1 constant pattern, 2 fixed line0 high sequence
  bit drop_mode = 0;     // downstream is stalled: completions behind a held bundle are lost

  // Microphone / reference model state: one entry per completed PDM period.
  int            bit_idx = 0;
  logic [W-1:0]  acc[NCH];
  bit            hi_pending = 0;
  logic [NL-1:0] hi_bits;
  int            low_run = 0;
  logic          prev_clk = 1'b0;

  always #5 clk = ~clk;

  pdm_ddr_deserializer #(
    .NUM_LINES (NL),
    .CLK_DIV   (DIV),
    .SAMPLE_DLY(SD),
    .WORD_W    (W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .pdm_clk  (pdm_clk),
    .pdm_data (pdm_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  function automatic logic pick_bit(input int line, input bit lo_half, input int idx);
    logic [7:0] seq;
    seq = 8'b1011_0010;
    case (mode)
      1: return (line == 0) ? !lo_half : lo_half;
      2: if (line == 0 && !lo_half) return seq[7 - (idx % 8)];
         else return 1'($urandom_range(0, 1));
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Microphones: drive a new bit right after each pdm_clk edge. Every full
  // period contributes one bit per channel; W periods make one bundle. A
  // stopped clock (low longer than half a period) discards the partial word.
  initial begin : mic_model
    logic [BW-1:0] b;
    pdm_data = '0;
    forever begin
      @(negedge clk);
      if (pdm_clk === 1'b1 && prev_clk === 1'b0) begin
        for (int l = 0; l < NL; l++) hi_bits[l] = pick_bit(l, 1'b0, bit_idx);
        pdm_data   = hi_bits;
        hi_pending = 1;
      end else if (pdm_clk === 1'b0 && prev_clk === 1'b1) begin
        for (int l = 0; l < NL; l++) pdm_data[l] = pick_bit(l, 1'b1, bit_idx);
        if (hi_pending) begin
          for (int l = 0; l < NL; l++) begin
            acc[2*l]   = {acc[2*l][W-2:0], hi_bits[l]};
            acc[2*l+1] = {acc[2*l+1][W-2:0], pdm_data[l]};
          end
          hi_pending = 0;
          bit_idx++;
          if (bit_idx == W) begin
            bit_idx = 0;
            for (int c = 0; c < NCH; c++) b[c*W +: W] = acc[c];
            if (drop_mode && exp_q.size() > 0) bundles_dropped++;
            else exp_q.push_back(b);
            bundles_made++;
          end
        end
      end
      if (pdm_clk !== 1'b1) low_run++;
      else low_run = 0;
      if (low_run > HALF) begin
        bit_idx    = 0;
        hi_pending = 0;
      end
      prev_clk = pdm_clk;
    end
  end

  // Scoreboard: every visible bundle must be the oldest expected one.
  initial begin : scoreboard
    forever begin
      @(negedge clk);
      #1;
      if (rst === 1'b0 && out_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL bundle_unexpected got=%h expected=none", out_data);
        end else begin
          if (out_data !== exp_q[0]) begin
            errors++;
            $display("FAIL bundle_data got=%h expected=%h", out_data, exp_q[0]);
          end
          if (out_ready === 1'b1) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_push(output bit ok);
    int prev;
    prev = bundles_made;
    ok = 0;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      #1;
      if (bundles_made != prev) begin
        ok = 1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bundle_completion_timeout got=none expected=bundle within 400 cycles");
    end
  endtask

  task automatic wait_rise(output bit ok);
    logic prev;
    prev = pdm_clk;
    ok = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      #1;
      if (pdm_clk === 1'b1 && prev === 1'b0) begin
        ok = 1;
        break;
      end
      prev = pdm_clk;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL pdm_clk_rise_timeout got=no edge expected=edge within 100 cycles");
    end
  endtask

  // Enable from IDLE and measure clk cycles until the first out_valid.
  task automatic start_and_time(input string name);
    int n;
    n = 0;
    @(negedge clk);
    en = 1'b1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      #1;
      if (out_valid === 1'b1) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n != LAT) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", name, n, LAT);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en = 1'b0;
    out_ready = 1'b0;
    ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({pdm_clk, out_valid, overflow} !== 3'b000 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=clk%b v%b ovf%b data=%h expected=all zero",
               pdm_clk, out_valid, overflow, out_data);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (pdm_clk !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_quiet got=clk%b v%b expected=clk0 v0", pdm_clk, out_valid);
    end
  endtask

  task automatic test_const_pattern();
    bit ok;
    int bad;
    mode = 1;
    out_ready = 1'b1;
    start_and_time("first_valid_latency");
    checks++;
    if (out_data !== 32'hFF0000FF) begin
      errors++;
      $display("FAIL const_pattern got=%h expected=%h", out_data, 32'hFF0000FF);
    end
    // Three full periods: 4 high samples then 4 low samples each.
    wait_rise(ok);
    bad = 0;
    for (int i = 0; i < 3 * DIV; i++) begin
      if (i > 0) begin
        @(negedge clk);
        #1;
      end
      if (pdm_clk !== ((i % DIV) < HALF)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL pdm_clk_shape got=%0d wrong samples expected=0", bad);
    end
  endtask

  task automatic test_msb_order();
    bit ok;
    bit seen;
    wait_push(ok);
    mode = 2;
    wait_push(ok);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      #1;
      if (out_valid === 1'b1) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen || out_data[7:0] !== 8'hB2) begin
      errors++;
      $display("FAIL msb_order got=%h (valid seen %0d) expected=b2", out_data[7:0], seen);
    end
    mode = 0;
  endtask

  task automatic test_overflow();
    bit ok;
    wait_push(ok);
    repeat (10) @(negedge clk);
    out_ready = 1'b0;
    drop_mode = 1;
    wait_push(ok);
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL held_first got=v%b ovf%b expected=v1 ovf0", out_valid, overflow);
    end
    wait_push(ok);
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (overflow !== 1'b1 || bundles_dropped != 1) begin
      errors++;
      $display("FAIL overflow_set got=ovf%b drops%0d expected=ovf1 drops1", overflow, bundles_dropped);
    end
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    #1;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear got=%b expected=0", overflow);
    end
    // Clear lands on the cycle the next completion is dropped: drop wins.
    wait_push(ok);
    @(negedge clk);
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    #1;
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow_set_priority got=%b expected=1", overflow);
    end
    repeat (10) @(negedge clk);
    out_ready = 1'b1;
    drop_mode = 0;
    repeat (5) @(negedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || overflow !== 1'b1) begin
      errors++;
      $display("FAIL drain_after_stall got=v%b ovf%b expected=v0 ovf1", out_valid, overflow);
    end
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
  endtask

  task automatic test_random_stream();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL random_no_overflow got=%b expected=0", overflow);
    end
  endtask

  task automatic test_stop_restart();
    bit ok;
    int highs;
    repeat ($urandom_range(1, 5)) wait_rise(ok);
    repeat (3) @(negedge clk);
    en = 1'b0;
    #1;
    checks++;
    if (pdm_clk !== 1'b1) begin
      errors++;
      $display("FAIL stop_high_half got=%b expected=1", pdm_clk);
    end
    highs = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      if (pdm_clk !== 1'b0) highs++;
    end
    checks++;
    if (highs != 0) begin
      errors++;
      $display("FAIL stop_clock_low got=%0d high samples expected=0", highs);
    end
    checks++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stop_drained got=q%0d v%b expected=q0 v0", exp_q.size(), out_valid);
    end
    start_and_time("restart_latency");
  endtask

  task automatic test_drain_resume();
    bit ok;
    int bad;
    wait_rise(ok);
    repeat (3) @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;
    bad = 0;
    for (int i = 0; i < 2 * DIV; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (pdm_clk !== (((5 + i) % DIV) < HALF)) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL drain_resume_clock got=%0d wrong samples expected=0", bad);
    end
    wait_push(ok);
    wait_push(ok);
  endtask

  task automatic test_reset_mid();
    bit ok;
    out_ready = 1'b0;
    wait_push(ok);
    repeat (5) @(negedge clk);
    wait_rise(ok);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    #1;
    checks++;
    if ({pdm_clk, out_valid, overflow} !== 3'b000 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_mid got=clk%b v%b ovf%b data=%h expected=all zero",
               pdm_clk, out_valid, overflow, out_data);
    end
    repeat (20) @(negedge clk);
    out_ready = 1'b1;
    start_and_time("post_reset_latency");
  endtask

  task automatic test_final_drain();
    bit done;
    @(negedge clk);
    en = 1'b0;
    done = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && out_valid === 1'b0 && pdm_clk === 1'b0) begin
        done = 1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL final_drain got=q%0d v%b expected=q0 v0", exp_q.size(), out_valid);
    end
  endtask

  initial begin : main
    test_reset();
    test_const_pattern();
    test_msb_order();
    test_overflow();
    test_random_stream();
    test_stop_restart();
    test_drain_resume();
    test_reset_mid();
    test_random_stream();
    test_final_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
